prbs_checker: RTL and testbench

- Receive-side counterpart of prbs_generator.
- Accepts 32-bit parallel words from the link under test and self-synchronises to the selected PRBS polynomial.
- Once locked, free-runs its own reference LFSR and counts bit errors, errored words and checked words.
- Used in loopback benches and on-chip BERT paths; the type encoding is identical to the generator's.

---
 rtl/prbs_pkg.sv | 79 +++++++
 rtl/prbs_popcount32.sv | 14 +
 rtl/prbs_checker.sv | 150 +++++++++++++++
 tb/tb_prbs_checker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: polynomial codes, order/tap lookup, checker states
// and the 32-step word generator used by both ends of the link.
package prbs_pkg;

    localparam logic [3:0] PRBS7  = 4'd0;
    localparam logic [3:0] PRBS9  = 4'd1;
    localparam logic [3:0] PRBS10 = 4'd2;
    localparam logic [3:0] PRBS11 = 4'd3;
    localparam logic [3:0] PRBS15 = 4'd4;
    localparam logic [3:0] PRBS20 = 4'd5;
    localparam logic [3:0] PRBS23 = 4'd6;
    localparam logic [3:0] PRBS29 = 4'd7;
    localparam logic [3:0] PRBS31 = 4'd8;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } chk_state_e;

    function automatic logic prbs_valid(input logic [3:0] sel);
        return sel <= PRBS31;
    endfunction

    // Invalid codes map to PRBS7 so callers never index outside the state.
    function automatic logic [4:0] prbs_order(input logic [3:0] sel);
        case (sel)
            PRBS9:   return 5'd9;
            PRBS10:  return 5'd10;
            PRBS11:  return 5'd11;
            PRBS15:  return 5'd15;
            PRBS20:  return 5'd20;
            PRBS23:  return 5'd23;
            PRBS29:  return 5'd29;
            PRBS31:  return 5'd31;
            default: return 5'd7;
        endcase
    endfunction

    function automatic logic [4:0] prbs_tap(input logic [3:0] sel);
        case (sel)
            PRBS9:   return 5'd5;
            PRBS10:  return 5'd7;
            PRBS11:  return 5'd9;
            PRBS15:  return 5'd14;
            PRBS20:  return 5'd3;
            PRBS23:  return 5'd18;
            PRBS29:  return 5'd27;
            PRBS31:  return 5'd28;
            default: return 5'd6;
        endcase
    endfunction

    function automatic logic [30:0] prbs_mask(input logic [4:0] n);
        logic [31:0] m;
        m = (32'd1 << n) - 32'd1;
        return m[30:0];
    endfunction

    // State bit 0 is the newest bit; the next N state bits equal word[N-1:0].
    function automatic logic [31:0] prbs_word(input logic [30:0] seed,
                                              input logic [4:0]  n,
                                              input logic [4:0]  t);
        logic [30:0] st;
        logic [30:0] m;
        logic [31:0] w;
        logic        nb;
        st = seed;
        m  = prbs_mask(n);
        w  = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            nb        = st[n - 5'd1] ^ st[t - 5'd1];
            w[31 - i] = nb;
            st        = ((st << 1) | {30'd0, nb}) & m;
        end
        return w;
    endfunction

endpackage

// File: rtl/prbs_popcount32.sv
// Combinational population count of a 32-bit error vector.
module prbs_popcount32 (
    input  logic [31:0] vec,
    output logic [5:0]  count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            count = count + {5'd0, vec[i]};
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS receiver: seeds from received data, verifies, then
// free-runs its reference LFSR and accumulates saturating error statistics.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter int unsigned ERR_THRESH = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clock,
    input  logic             init_n,
    input  logic [3:0]       prbs_type,   // "type" is a reserved word
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_word,
    output logic [5:0]       bit_err_num,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic [7:0]       LOCK_LIM   = 8'(LOCK_CNT);
    localparam logic [7:0]       UNLOCK_LIM = 8'(UNLOCK_CNT);
    localparam logic [5:0]       THRESH     = 6'(ERR_THRESH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    chk_state_e       state_q, state_d;
    logic [30:0]      lfsr_q, lfsr_d;
    logic [7:0]       good_q, good_d;
    logic [7:0]       bad_q, bad_d;
    logic [3:0]       type_q;
    logic             err_word_d;
    logic [5:0]       bit_err_d;
    logic [CNT_W-1:0] err_cnt_d, word_cnt_d;

    logic [4:0]       n, t;
    logic [30:0]      mask, seed, next_state;
    logic [31:0]      predicted, err_vec;
    logic [5:0]       pop;
    logic [CNT_W:0]   err_sum;

    assign n          = prbs_order(prbs_type);
    assign t          = prbs_tap(prbs_type);
    assign mask       = prbs_mask(n);
    assign seed       = in_data[30:0] & mask;
    assign predicted  = prbs_word(lfsr_q, n, t);
    assign next_state = predicted[30:0] & mask;
    assign err_vec    = in_data ^ predicted;
    assign err_sum    = {1'b0, err_cnt} + {{(CNT_W-5){1'b0}}, pop};

    prbs_popcount32 u_popcount (
        .vec   (err_vec),
        .count (pop)
    );

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        good_d     = good_q;
        bad_d      = bad_q;
        err_word_d = 1'b0;
        bit_err_d  = bit_err_num;
        err_cnt_d  = err_cnt;
        word_cnt_d = word_cnt;

        if (prbs_type != type_q) begin
            state_d = SEARCH;
            good_d  = '0;
            bad_d   = '0;
        end else if (in_valid) begin
            case (state_q)
                SEARCH: begin
                    if (prbs_valid(prbs_type) && seed != '0) begin
                        lfsr_d  = seed;
                        good_d  = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (pop == '0) begin
                        lfsr_d = next_state;
                        good_d = good_q + 8'd1;
                        if (good_d == LOCK_LIM) begin
                            state_d = LOCKED;
                            bad_d   = '0;
                        end
                    end else begin
                        lfsr_d = seed;
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    // Free-run from our own prediction so line errors never reseed.
                    lfsr_d     = next_state;
                    err_word_d = (pop != '0);
                    bit_err_d  = pop;
                    err_cnt_d  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
                    if (word_cnt != '1) begin
                        word_cnt_d = word_cnt + CNT_ONE;
                    end
                    if (pop > THRESH) begin
                        bad_d = bad_q + 8'd1;
                        if (bad_d == UNLOCK_LIM) begin
                            state_d = SEARCH;
                            bad_d   = '0;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        if (clr_cnt) begin
            err_cnt_d  = '0;
            word_cnt_d = '0;
            bad_d      = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!init_n) begin
            state_q     <= SEARCH;
            lfsr_q      <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            type_q      <= prbs_type;
            err_word    <= 1'b0;
            bit_err_num <= '0;
            err_cnt     <= '0;
            word_cnt    <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            type_q      <= prbs_type;
            err_word    <= err_word_d;
            bit_err_num <= bit_err_d;
            err_cnt     <= err_cnt_d;
            word_cnt    <= word_cnt_d;
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: bit-level reference sequence, per-word
// expectations queued on drive and checked after the sampling edge.
module tb_prbs_checker;

    logic        clock = 1'b0;
    logic        init_n;
    logic [3:0]  prbs_type;
    logic        in_valid;
    logic [31:0] in_data;
    logic        clr_cnt;
    logic        locked;
    logic        err_word;
    logic [5:0]  bit_err_num;
    logic [31:0] err_cnt;
    logic [31:0] word_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit lock;
        int err;   // -2: skip, -1: err_word must be 0, >=0: exact count
    } exp_t;
    exp_t sb[$];

    bit s[$];
    int gen_n, gen_t;

    prbs_checker #(
        .LOCK_CNT   (4),
        .UNLOCK_CNT (4),
        .ERR_THRESH (8),
        .CNT_W      (32)
    ) dut (
        .clock       (clock),
        .init_n      (init_n),
        .prbs_type   (prbs_type),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .clr_cnt     (clr_cnt),
        .locked      (locked),
        .err_word    (err_word),
        .bit_err_num (bit_err_num),
        .err_cnt     (err_cnt),
        .word_cnt    (word_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic gen_init(input int n, input int t);
        s.delete();
        gen_n = n;
        gen_t = t;
        for (int i = 0; i < n; i++) s.push_back(1'b1);
    endtask

    // s[k] = s[k-N] ^ s[k-T], first bit of the word in bit 31
    task automatic next_word(output logic [31:0] w);
        bit b;
        for (int j = 0; j < 32; j++) begin
            b = s[s.size() - gen_n] ^ s[s.size() - gen_t];
            s.push_back(b);
            w[31 - j] = b;
        end
    endtask

    task automatic send(input logic [31:0] d, input bit clr, input bit lk, input int e);
        exp_t x;
        x.lock = lk;
        x.err  = e;
        sb.push_back(x);
        in_valid = 1'b1;
        in_data  = d;
        clr_cnt  = clr;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
        x = sb.pop_front();
        check("locked", 64'(locked), 64'(x.lock));
        if (x.err == -1) begin
            check("err_word_idle", 64'(err_word), 64'd0);
        end else if (x.err >= 0) begin
            check("err_word", 64'(err_word), 64'(x.err != 0));
            check("bit_err_num", 64'(bit_err_num), 64'(x.err));
        end
    endtask

    task automatic restart(input logic [3:0] ty);
        prbs_type = ty;
        init_n    = 1'b0;
        in_valid  = 1'b0;
        clr_cnt   = 1'b0;
        @(posedge clock);
        #1;
        init_n = 1'b1;
    endtask

    task automatic acquire();
        logic [31:0] w;
        for (int i = 0; i < 5; i++) begin
            next_word(w);
            send(w, 1'b0, i == 4, -1);
        end
    endtask

    task automatic clean(input int cnt);
        logic [31:0] w;
        for (int i = 0; i < cnt; i++) begin
            next_word(w);
            send(w, 1'b0, 1'b1, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, 64'(locked), 64'd0);
        check({tag, "_err_word"}, 64'(err_word), 64'd0);
        check({tag, "_bit_err_num"}, 64'(bit_err_num), 64'd0);
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
        check({tag, "_word_cnt"}, 64'(word_cnt), 64'd0);
    endtask

    initial begin
        logic [31:0] w;
        in_data = '0;

        // PRBS7 clean stream from reset
        restart(4'd0);
        check_all_zero("reset");
        gen_init(7, 6);
        acquire();
        clean(127);
        check("prbs7_word_cnt", 64'(word_cnt), 64'd127);
        check("prbs7_err_cnt", 64'(err_cnt), 64'd0);

        // PRBS31 single bit error
        restart(4'd8);
        gen_init(31, 28);
        acquire();
        clean(3);
        next_word(w);
        send(w ^ 32'h1, 1'b0, 1'b1, 1);
        check("prbs31_err_cnt", 64'(err_cnt), 64'd1);
        clean(1);
        check("prbs31_word_cnt", 64'(word_cnt), 64'd5);

        // PRBS15 burst of four inverted words drops and regains lock
        restart(4'd4);
        gen_init(15, 14);
        acquire();
        clean(2);
        for (int i = 0; i < 4; i++) begin
            next_word(w);
            send(~w, 1'b0, i != 3, 32);
        end
        check("prbs15_err_cnt", 64'(err_cnt), 64'd128);
        check("prbs15_word_cnt", 64'(word_cnt), 64'd6);
        for (int i = 0; i < 5; i++) begin
            next_word(w);
            send(w, 1'b0, i == 4, -2);
        end
        check("prbs15_err_cnt_kept", 64'(err_cnt), 64'd128);

        // All-zero input never seeds
        restart(4'd2);
        for (int i = 0; i < 8; i++) send(32'h0, 1'b0, 1'b0, 0);
        check("zero_err_cnt", 64'(err_cnt), 64'd0);
        check("zero_word_cnt", 64'(word_cnt), 64'd0);

        // Invalid type, then switch to PRBS10 during an idle cycle
        restart(4'd9);
        gen_init(10, 7);
        for (int i = 0; i < 8; i++) begin
            next_word(w);
            send(w, 1'b0, 1'b0, 0);
        end
        prbs_type = 4'd2;
        @(posedge clock);
        #1;
        check("type_switch_locked", 64'(locked), 64'd0);
        acquire();

        // Reset while locked with accumulated errors
        next_word(w);
        send(w ^ 32'h0000_001F, 1'b0, 1'b1, 5);
        check("pre_reset_err_cnt", 64'(err_cnt), 64'd5);
        init_n = 1'b0;
        @(posedge clock);
        #1;
        init_n = 1'b1;
        check_all_zero("midreset");
        acquire();

        // Clear wins over a concurrent errored word
        clean(1);
        check("pre_clr_word_cnt", 64'(word_cnt), 64'd1);
        next_word(w);
        send(w ^ 32'h8000_0101, 1'b1, 1'b1, 3);
        check("clr_err_cnt", 64'(err_cnt), 64'd0);
        check("clr_word_cnt", 64'(word_cnt), 64'd0);
        clean(1);
        check("post_clr_word_cnt", 64'(word_cnt), 64'd1);
        check("post_clr_err_cnt", 64'(err_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
